// File: rtl/input_window_buffer_if.sv
// Handshake bundle for input_window_buffer: input beat stream in, windowed beats out.
// The DUT takes the slave modport; the upstream/downstream side takes master.
interface input_window_buffer_if #(
    parameter int ISSUE_WIDTH = 16,
    parameter int LOOKAHEAD   = 4,
    parameter int ADDR_WIDTH  = 32
);
    localparam int LEN_W = $clog2(ISSUE_WIDTH + 1);
    localparam int OUT_W = (ISSUE_WIDTH + LOOKAHEAD) * 8;

    logic                     input_valid;
    logic                     input_ready;
    logic                     input_delim;
    logic [LEN_W-1:0]         input_len;
    logic [ISSUE_WIDTH*8-1:0] input_data;

    logic                     output_valid;
    logic                     output_ready;
    logic                     output_delim;
    logic [ADDR_WIDTH-1:0]    output_head_addr;
    logic [OUT_W-1:0]         output_data;
    logic [ISSUE_WIDTH-1:0]   output_mask;

    modport slave (
        input  input_valid,
        input  input_delim,
        input  input_len,
        input  input_data,
        input  output_ready,
        output input_ready,
        output output_valid,
        output output_delim,
        output output_head_addr,
        output output_data,
        output output_mask
    );

    modport master (
        output input_valid,
        output input_delim,
        output input_len,
        output input_data,
        output output_ready,
        input  input_ready,
        input  output_valid,
        input  output_delim,
        input  output_head_addr,
        input  output_data,
        input  output_mask
    );
endinterface

// File: rtl/input_window_buffer.sv
// One-beat window buffer: emits each beat with LOOKAHEAD bytes borrowed from the next.
// Define INPUT_WINDOW_BLOCK_ADDR_RESET_EN to restart head_addr at 0 for every block.
module input_window_buffer #(
    parameter int ISSUE_WIDTH = 16,
    parameter int LOOKAHEAD   = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    input_window_buffer_if.slave bus
);
    localparam int LEN_W = $clog2(ISSUE_WIDTH + 1);
    localparam int IW8   = ISSUE_WIDTH * 8;
    localparam int LA8   = LOOKAHEAD * 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                 state;
    logic [IW8-1:0]         held_data;
    logic [LEN_W-1:0]       held_len;
    logic                   held_delim;
    logic [ADDR_WIDTH-1:0]  head_addr;

    logic                   accept;
    logic                   fire;
    logic [IW8-1:0]         flush_data;
    logic [ISSUE_WIDTH-1:0] flush_mask;

    // Handshake: HOLD needs the successor beat before it can emit.
    always_comb begin
        bus.input_ready  = 1'b1;
        bus.output_valid = 1'b0;
        unique case (state)
            EMPTY: begin
                bus.input_ready  = 1'b1;
                bus.output_valid = 1'b0;
            end
            HOLD: begin
                bus.input_ready  = bus.output_ready;
                bus.output_valid = bus.input_valid;
            end
            FLUSH: begin
                bus.input_ready  = bus.output_ready;
                bus.output_valid = 1'b1;
            end
            default: begin
                bus.input_ready  = 1'b1;
                bus.output_valid = 1'b0;
            end
        endcase
    end

    assign accept = bus.input_valid && bus.input_ready;
    assign fire   = bus.output_valid && bus.output_ready;

    // Last beat of a block: zero bytes past the length, mask windows that overrun it.
    always_comb begin
        flush_data = '0;
        flush_mask = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (i < int'(held_len)) begin
                flush_data[i*8 +: 8] = held_data[i*8 +: 8];
            end
            if (i + LOOKAHEAD < int'(held_len)) begin
                flush_mask[i] = 1'b1;
            end
        end
    end

    // Output window: lookahead comes live from the input in HOLD, zeros in FLUSH.
    always_comb begin
        bus.output_data  = '0;
        bus.output_mask  = '0;
        bus.output_delim = 1'b0;
        unique case (state)
            HOLD: begin
                bus.output_data = {bus.input_data[LA8-1:0], held_data};
                bus.output_mask = '1;
            end
            FLUSH: begin
                bus.output_data  = {{LA8{1'b0}}, flush_data};
                bus.output_mask  = flush_mask;
                bus.output_delim = held_delim;
            end
            default: begin
                bus.output_data  = '0;
                bus.output_mask  = '0;
                bus.output_delim = 1'b0;
            end
        endcase
    end

    assign bus.output_head_addr = head_addr;

    // Beat holding register and state; non-delim beats always count as full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            held_data  <= '0;
            held_len   <= '0;
            held_delim <= 1'b0;
        end else if (accept) begin
            held_data  <= bus.input_data;
            held_delim <= bus.input_delim;
            held_len   <= bus.input_delim ? bus.input_len
                                          : LEN_W'(ISSUE_WIDTH);
            state      <= bus.input_delim ? FLUSH : HOLD;
        end else if (fire && state == FLUSH) begin
            state <= EMPTY;
        end
    end

    // Head address advances one beat per emitted window and wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_addr <= '0;
        end else if (fire) begin
`ifdef INPUT_WINDOW_BLOCK_ADDR_RESET_EN
            if (state == FLUSH) begin
                head_addr <= '0;
            end else begin
                head_addr <= head_addr + ADDR_WIDTH'(ISSUE_WIDTH);
            end
`else
            head_addr <= head_addr + ADDR_WIDTH'(ISSUE_WIDTH);
`endif
        end
    end
endmodule

// File: tb/tb_input_window_buffer.sv
// Scoreboard bench for input_window_buffer (plus a narrow-address copy for wrap).
// Expected windows are queued as beats are driven and popped on each output fire.
module tb_input_window_buffer;
    localparam int IW  = 16;
    localparam int LA  = 4;
    localparam int AW  = 32;
    localparam int SAW = 6;
    localparam int DW  = (IW + LA) * 8;
    localparam int LW  = $clog2(IW + 1);

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] mask;
        logic          delim;
        logic [AW-1:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_window_buffer_if #(.ISSUE_WIDTH(IW), .LOOKAHEAD(LA), .ADDR_WIDTH(AW)) bus ();
    input_window_buffer_if #(.ISSUE_WIDTH(IW), .LOOKAHEAD(LA), .ADDR_WIDTH(SAW)) sbus ();

    input_window_buffer #(.ISSUE_WIDTH(IW), .LOOKAHEAD(LA), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    input_window_buffer #(.ISSUE_WIDTH(IW), .LOOKAHEAD(LA), .ADDR_WIDTH(SAW)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    assign sbus.input_valid  = bus.input_valid;
    assign sbus.input_delim  = bus.input_delim;
    assign sbus.input_len    = bus.input_len;
    assign sbus.input_data   = bus.input_data;
    assign sbus.output_ready = bus.output_ready;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t e;
    logic [AW-1:0] m_addr = '0;
    logic [IW*8-1:0] m_prev = '0;
    bit m_have = 1'b0;

    task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [IW*8-1:0] make_beat(logic [7:0] base);
        logic [IW*8-1:0] b;
        for (int i = 0; i < IW; i++) b[i*8 +: 8] = base + 8'(i);
        return b;
    endfunction

    function automatic void push_hold(logic [IW*8-1:0] prev, logic [IW*8-1:0] cur);
        exp_t x;
        for (int b = 0; b < IW + LA; b++) begin
            if (b < IW) x.data[b*8 +: 8] = prev[b*8 +: 8];
            else        x.data[b*8 +: 8] = cur[(b-IW)*8 +: 8];
        end
        x.mask  = '1;
        x.delim = 1'b1 ^ 1'b1;
        x.addr  = m_addr;
        m_addr  = m_addr + AW'(IW);
        sb.push_back(x);
    endfunction

    function automatic void push_flush(logic [IW*8-1:0] cur, int len);
        exp_t x;
        x.data = '0;
        x.mask = '0;
        for (int b = 0; b < len && b < IW; b++) x.data[b*8 +: 8] = cur[b*8 +: 8];
        for (int i = 0; i < IW; i++) x.mask[i] = (i + LA < len);
        x.delim = 1'b1;
        x.addr  = m_addr;
`ifdef INPUT_WINDOW_BLOCK_ADDR_RESET_EN
        m_addr = '0;
`else
        m_addr = m_addr + AW'(IW);
`endif
        sb.push_back(x);
    endfunction

    // Present a beat, queue what it makes visible, and wait for its acceptance.
    task automatic send_beat(logic [IW*8-1:0] d, logic dl, int len);
        bit ok;
        bit acc;
        acc = 1'b0;
        bus.input_data  = d;
        bus.input_delim = dl;
        bus.input_len   = LW'(len);
        bus.input_valid = 1'b1;
        if (m_have) push_hold(m_prev, d);
        if (dl) begin
            push_flush(d, len);
            m_have = 1'b0;
        end else begin
            m_prev = d;
            m_have = 1'b1;
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            ok = bus.input_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle();
        bus.input_valid = 1'b0;
        bus.input_delim = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        #1;
        if (sb.size() != 0) check("drain_timeout", DW'(sb.size()), 0);
    endtask

    // Output monitor: every fire must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.output_valid && bus.output_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", bus.output_data, e.data);
                check("out_mask", DW'(bus.output_mask), DW'(e.mask));
                check("out_delim", DW'(bus.output_delim), DW'(e.delim));
                check("out_addr", DW'(bus.output_head_addr), DW'(e.addr));
                check("small_valid", DW'(sbus.output_valid), 1);
                check("small_addr_wrap", DW'(sbus.output_head_addr),
                      DW'(e.addr[SAW-1:0]));
            end
            if (bus.output_delim && bus.input_valid)
                check("turnaround_ready", DW'(bus.input_ready), 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW*8-1:0] bx;
        logic [IW*8-1:0] by;
        logic [DW-1:0] stall_exp;

        bus.input_valid  = 1'b0;
        bus.input_delim  = 1'b0;
        bus.input_len    = '0;
        bus.input_data   = '0;
        bus.output_ready = 1'b1;

        #1;
        check("rst_valid", DW'(bus.output_valid), 0);
        check("rst_delim", DW'(bus.output_delim), 0);
        check("rst_mask", DW'(bus.output_mask), 0);
        check("rst_addr", DW'(bus.output_head_addr), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_ready", DW'(bus.input_ready), 1);
        check("rst_valid_rel", DW'(bus.output_valid), 0);

        // Three full beats then a full-length delim beat.
        send_beat(make_beat(8'd0), 1'b0, 0);
        send_beat(make_beat(8'd16), 1'b0, 0);
        send_beat(make_beat(8'd32), 1'b0, 5);
        send_beat(make_beat(8'd48), 1'b1, 16);
        idle();
        drain();

        // Short delim beat with filler bytes past its length.
        send_beat(make_beat(8'h60), 1'b0, 0);
        bx = {IW{8'h55}};
        for (int i = 0; i < 6; i++) bx[i*8 +: 8] = 8'hAA + 8'(i);
        send_beat(bx, 1'b1, 6);
        idle();
        drain();

        // Lengths at and below the lookahead.
        send_beat(make_beat(8'h80), 1'b1, 3);
        idle();
        drain();
        send_beat(make_beat(8'h90), 1'b1, 0);
        idle();
        drain();

        // Back-to-back blocks with no idle cycle between them.
        send_beat(make_beat(8'hA0), 1'b0, 0);
        send_beat(make_beat(8'hB0), 1'b1, 16);
        send_beat(make_beat(8'hC0), 1'b0, 0);
        send_beat(make_beat(8'hD0), 1'b0, 0);
        send_beat(make_beat(8'hE0), 1'b1, 10);
        idle();
        drain();

        // Downstream stall in HOLD with the successor beat waiting.
        bx = make_beat(8'h11);
        by = make_beat(8'h31);
        for (int b = 0; b < IW + LA; b++)
            stall_exp[b*8 +: 8] = (b < IW) ? bx[b*8 +: 8] : by[(b-IW)*8 +: 8];
        send_beat(bx, 1'b0, 0);
        bus.output_ready = 1'b0;
        fork
            send_beat(by, 1'b0, 0);
            begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("stall_data", bus.output_data, stall_exp);
                    check("stall_ready", DW'(bus.input_ready), 0);
                    check("stall_valid", DW'(bus.output_valid), 1);
                end
                @(posedge clk);
                #1;
                bus.output_ready = 1'b1;
            end
        join
        send_beat(make_beat(8'h51), 1'b1, 12);
        idle();
        drain();

        // Long block so the narrow-address copy wraps even with per-block addressing.
        for (int k = 0; k < 5; k++) send_beat(make_beat(8'(k * 16)), 1'b0, 0);
        send_beat(make_beat(8'h70), 1'b1, 16);
        idle();
        drain();

        // Asynchronous reset while a delim beat is stuck in FLUSH.
        bus.output_ready = 1'b0;
        send_beat(make_beat(8'hF0), 1'b1, 16);
        idle();
        #3;
        check("flush_valid", DW'(bus.output_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", DW'(bus.output_valid), 0);
        check("async_rst_addr", DW'(bus.output_head_addr), 0);
        sb.delete();
        m_addr = '0;
        m_have = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.output_ready = 1'b1;
        #1;
        check("post_rst_ready", DW'(bus.input_ready), 1);
        check("post_rst_valid", DW'(bus.output_valid), 0);
        send_beat(make_beat(8'h21), 1'b0, 0);
        send_beat(make_beat(8'h41), 1'b1, 8);
        idle();
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/input_window_buffer.md
INPUT_WINDOW_BUFFER -- requirements
Module: input_window_buffer

Interface
REQ-001 SHALL have parameter ISSUE_WIDTH, default 16, bytes per input beat (legal range 2..64).
REQ-002 SHALL have parameter LOOKAHEAD, default 4, bytes borrowed from the next beat (legal range 1..ISSUE_WIDTH); hash window = LOOKAHEAD+1 bytes.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports input_valid (in, 1), input_ready (out, 1), input_delim (in, 1, last beat of block), input_len (in, $clog2(ISSUE_WIDTH+1), valid-byte count, used only when input_delim=1), input_data (in, ISSUE_WIDTH*8, byte 0 in bits [7:0]).
REQ-007 SHALL have ports output_valid (out, 1), output_ready (in, 1), output_delim (out, 1), output_head_addr (out, ADDR_WIDTH), output_data (out, (ISSUE_WIDTH+LOOKAHEAD)*8), output_mask (out, ISSUE_WIDTH, bit i = window at byte i fully valid).

Function
REQ-008 SHALL implement states EMPTY (nothing held), HOLD (non-delim beat held), FLUSH (delim beat held).
REQ-009 Input acceptance SHALL store input_data, input_delim and length (ISSUE_WIDTH for non-delim beats, input_len for delim beats) into held registers; next state FLUSH if delim else HOLD.
REQ-010 input_ready SHALL be 1 in EMPTY, output_ready in HOLD, output_ready in FLUSH.
REQ-011 output_valid SHALL be 0 in EMPTY, input_valid in HOLD, 1 in FLUSH.
REQ-012 In HOLD, output_data SHALL be {input_data[LOOKAHEAD*8-1:0], held_data}, output_delim=0, output_mask all ones.
REQ-013 In FLUSH, output_data SHALL be {LOOKAHEAD zero bytes, held_data with bytes at index >= held_len forced to zero}, output_delim=1.
REQ-014 In FLUSH, output_mask bit i SHALL be 1 iff i+LOOKAHEAD < held_len; held_len <= LOOKAHEAD gives all-zero mask.
REQ-015 HOLD output fire (output_valid && output_ready) SHALL simultaneously consume the current input beat per REQ-009.
REQ-016 FLUSH output fire SHALL accept a concurrently valid input beat per REQ-009 (zero-bubble block turnaround), else go to EMPTY.
REQ-017 output_head_addr SHALL equal head_addr register; it SHALL increment by ISSUE_WIDTH on every output fire, modulo 2^ADDR_WIDTH (wrap silently).
REQ-018 Non-delim beats SHALL be treated as full regardless of input_len.
REQ-019 Outputs SHALL be stable while output_valid=1 and output_ready=0, given stable inputs.
REQ-020 Latency: held beat emitted in the same cycle its successor is presented (HOLD) or the cycle after acceptance (FLUSH); no internal buffering beyond one beat.

Reset
REQ-021 rst_n low SHALL asynchronously force state EMPTY, head_addr 0, held data/len/delim 0.
REQ-022 During and immediately after reset: output_valid=0, output_delim=0, output_mask=0, output_head_addr=0, input_ready=1 once rst_n released.
REQ-023 Reset mid-operation SHALL discard any held beat without emitting it.

Configuration
REQ-024 Macro INPUT_WINDOW_BLOCK_ADDR_RESET_EN defined: FLUSH output fire SHALL set head_addr to 0 (per-block addressing).
REQ-025 Macro undefined: FLUSH output fire SHALL increment head_addr by ISSUE_WIDTH like any other fire (global stream addressing).

Verification (ISSUE_WIDTH=16, LOOKAHEAD=4, ADDR_WIDTH=32)
REQ-026 Stream bytes 0..47 as three non-delim beats then delim beat len=16 bytes 48..63, output_ready=1 -> outputs head_addr 0,16,32,48; data 0..19, 16..35, 32..51, then 48..63 plus 4 zero bytes; masks FFFF,FFFF,FFFF,0FFF; last delim=1.
REQ-027 Delim beat len=6 with bytes AA..AF after one full beat -> FLUSH data bytes 6..19 zero, mask 0x0003, delim=1.
REQ-028 Delim beat len=3 -> mask 0x0000; len=0 -> mask 0x0000, data all zero, head_addr still advances per REQ-017/024/025.
REQ-029 Back-to-back blocks, new beat valid during FLUSH fire -> next cycle state HOLD, no idle cycle; macro on: second block head_addr 0; macro off: 64.
REQ-030 output_ready=0 for 5 cycles in HOLD with input_valid=1 -> output_data stable, input_ready=0, no beat lost; head_addr at 0xFFFFFFF0 fire -> wraps to 0x00000000.
REQ-031 Assert rst_n=0 asynchronously mid-FLUSH -> output_valid drops before next clock edge; after release first accepted beat reports head_addr 0.
